// File: rtl/proj_pkg.sv
// Shared types and sizes for the MinHash projection stage.
package proj_pkg;

    localparam int FM_BUFFER_SIZE = 32;
    localparam int SEQ_PASS_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_e;

endpackage

// File: rtl/proj_index_sequencer_if.sv
// Index stream from the sequencer to the FM buffer read port.
interface proj_index_sequencer_if
    import proj_pkg::*;
#(
    parameter int IDX_W = $clog2(FM_BUFFER_SIZE),
    parameter int PASS_W = SEQ_PASS_W
);

    logic [IDX_W-1:0]  index;
    logic              index_valid;
    logic              index_ready;
    logic [PASS_W-1:0] pass_idx;
    logic              last;

    modport master (
        output index,
        output index_valid,
        output pass_idx,
        output last,
        input  index_ready
    );

    modport slave (
        input  index,
        input  index_valid,
        input  pass_idx,
        input  last,
        output index_ready
    );

endinterface

// File: rtl/proj_wrap_counter.sv
// Enabled up-counter that returns to zero after reaching limit;
// wrap flags the enabled cycle at the limit so counters can cascade.
module proj_wrap_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = en && (count == limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/proj_index_sequencer.sv
// Programmable index/pass generator that walks the FM buffer with
// a valid/ready stream, abort, and busy/done/error status.
module proj_index_sequencer
    import proj_pkg::*;
#(
    parameter int MAX_LEN = FM_BUFFER_SIZE,
    parameter int IDX_W = $clog2(MAX_LEN),
    parameter int PASS_W = SEQ_PASS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W:0]    cfg_len,
    input  logic [PASS_W-1:0] cfg_passes,
    input  logic              abort,
    proj_index_sequencer_if.master seq,
    output logic              busy,
    output logic              done,
    output logic              finished_count,
    output logic              cfg_err
);

    seq_state_e state_q, state_d;

    logic [IDX_W:0]    len_q;
    logic [PASS_W-1:0] passes_q;
    logic [IDX_W-1:0]  idx;
    logic [PASS_W-1:0] pass;
    logic [IDX_W-1:0]  idx_lim;
    logic [PASS_W-1:0] pass_lim;
    logic              cfg_ok;
    logic              start_ok;
    logic              run;
    logic              kill;
    logic              accept;
    logic              idx_wrap;
    logic              pass_wrap;
    logic              clr;

    assign cfg_ok = (cfg_len != '0)
                 && (cfg_len <= (IDX_W+1)'(MAX_LEN))
                 && (cfg_passes != '0);

    assign run      = (state_q == RUN);
    assign start_ok = (state_q == IDLE) && start && cfg_ok;
    assign kill     = run && abort;
    assign accept   = run && seq.index_ready && !abort;
    assign clr      = start_ok || kill;

    // len is at most MAX_LEN, so len-1 always fits in IDX_W bits
    assign idx_lim  = IDX_W'(len_q - 1'b1);
    assign pass_lim = passes_q - 1'b1;

    proj_wrap_counter #(.W(IDX_W)) u_idx (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (accept),
        .limit (idx_lim),
        .count (idx),
        .wrap  (idx_wrap)
    );

    proj_wrap_counter #(.W(PASS_W)) u_pass (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (idx_wrap),
        .limit (pass_lim),
        .count (pass),
        .wrap  (pass_wrap)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN: begin
                if (abort)          state_d = IDLE;
                else if (pass_wrap) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            len_q          <= '0;
            passes_q       <= '0;
            finished_count <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_err <= (state_q == IDLE) && start && !cfg_ok;
            if (start_ok) begin
                len_q          <= cfg_len;
                passes_q       <= cfg_passes;
                finished_count <= 1'b0;
            end else if (pass_wrap) begin
                finished_count <= 1'b1;
            end
        end
    end

    assign busy            = run;
    assign done            = (state_q == DONE);
    assign seq.index       = idx;
    assign seq.pass_idx    = pass;
    assign seq.index_valid = run;
    assign seq.last        = run && (idx == idx_lim) && (pass == pass_lim);

endmodule

// File: tb/tb_proj_index_sequencer.sv
// Randomised and directed checks of proj_index_sequencer against a
// beat-counting reference model.
module tb_proj_index_sequencer;
    import proj_pkg::*;

    localparam int MAX_LEN = FM_BUFFER_SIZE;
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int PASS_W = SEQ_PASS_W;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [IDX_W:0] cfg_len;
    logic [PASS_W-1:0] cfg_passes;
    logic abort;
    logic busy, done, finished_count, cfg_err;

    always #5 clk = ~clk;

    proj_index_sequencer_if #(.IDX_W(IDX_W), .PASS_W(PASS_W)) sif ();

    proj_index_sequencer #(
        .MAX_LEN (MAX_LEN),
        .IDX_W   (IDX_W),
        .PASS_W  (PASS_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_len        (cfg_len),
        .cfg_passes     (cfg_passes),
        .abort          (abort),
        .seq            (sif),
        .busy           (busy),
        .done           (done),
        .finished_count (finished_count),
        .cfg_err        (cfg_err)
    );

    int errors = 0;
    int checks = 0;

    // reference model: phase 0 idle, 1 sweeping, 2 completion cycle;
    // k counts accepted beats of the current run
    int ph, k, mlen, mp, mfin, mcerr;
    int beats, max_idx;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; k = 0; mlen = 1; mp = 1; mfin = 0; mcerr = 0;
    endtask

    task automatic check_outputs();
        int run = (ph == 1) ? 1 : 0;
        int tot = mlen * mp;
        chk("busy", 32'(busy), run);
        chk("index_valid", 32'(sif.index_valid), run);
        chk("index", 32'(sif.index), run != 0 ? k % mlen : 0);
        chk("pass_idx", 32'(sif.pass_idx), run != 0 ? k / mlen : 0);
        chk("last", 32'(sif.last), (run != 0 && k == tot - 1) ? 1 : 0);
        chk("done", 32'(done), ph == 2 ? 1 : 0);
        chk("finished_count", 32'(finished_count), mfin);
        chk("cfg_err", 32'(cfg_err), mcerr);
    endtask

    task automatic step(input int st, input int l, input int p,
                        input int ab, input int rdy);
        start = 1'(st);
        cfg_len = (IDX_W+1)'(l);
        cfg_passes = PASS_W'(p);
        abort = 1'(ab);
        sif.index_ready = 1'(rdy);
        check_outputs();
        if (sif.index_valid === 1'b1 && rdy != 0) begin
            beats++;
            if (int'(sif.index) > max_idx) max_idx = int'(sif.index);
        end
        @(posedge clk);
        mcerr = 0;
        case (ph)
            0: if (st != 0) begin
                if (l >= 1 && l <= MAX_LEN && p != 0) begin
                    mlen = l; mp = p; k = 0; mfin = 0; ph = 1;
                end else begin
                    mcerr = 1;
                end
            end
            1: if (ab != 0) begin
                ph = 0; k = 0;
            end else if (rdy != 0) begin
                k++;
                if (k == mlen * mp) begin
                    ph = 2; k = 0; mfin = 1;
                end
            end
            default: ph = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic run_to_idle(input int toggle);
        int i = 0;
        while (ph != 0 && i < 2000) begin
            step(0, 0, 0, 0, toggle != 0 ? ((i % 2) == 0 ? 1 : 0) : 1);
            i++;
        end
        chk("run_ends", 32'(ph), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; cfg_len = '0; cfg_passes = '0; abort = 1'b0;
        sif.index_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // single pass of 8, ready held high
        step(1, 8, 1, 0, 1);
        run_to_idle(0);
        repeat (3) step(0, 0, 0, 0, 1);

        // 4 x 3 with ready toggling
        beats = 0;
        step(1, 4, 3, 0, 1);
        run_to_idle(1);
        chk("beats_4x3", 32'(beats), 12);

        // full-length sweep
        max_idx = 0;
        step(1, MAX_LEN, 1, 0, 1);
        run_to_idle(0);
        chk("max_index", 32'(max_idx), MAX_LEN - 1);
        chk("finished_full", 32'(finished_count), 1);

        // abort at index 5, then a fresh run
        step(1, 16, 1, 0, 1);
        for (int i = 0; i < 16 && k < 5; i++) step(0, 0, 0, 0, 1);
        chk("abort_at", 32'(sif.index), 5);
        step(0, 0, 0, 1, 1);
        chk("after_abort_fin", 32'(finished_count), 0);
        step(1, 5, 2, 0, 1);
        run_to_idle(0);

        // rejected configurations and start during a run
        step(1, 0, 1, 0, 1);
        step(1, 5, 0, 0, 1);
        step(1, MAX_LEN + 1, 2, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 6, 1, 0, 1);
        step(1, 3, 2, 0, 1);
        step(1, 2, 5, 0, 0);
        run_to_idle(0);

        // asynchronous reset mid-run
        step(1, 8, 2, 0, 1);
        for (int i = 0; i < 8 && k < 3; i++) step(0, 0, 0, 0, 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        step(1, 4, 1, 0, 1);
        chk("restart_index", 32'(sif.index), 0);
        run_to_idle(0);

        // random runs
        for (int r = 0; r < 25; r++) begin
            int l = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, MAX_LEN));
            int p = int'($urandom_range(0, 3));
            int n = 0;
            step(1, l, p, 0, 1);
            while (ph != 0 && n < 400) begin
                step(($urandom % 8 == 0) ? 1 : 0,
                     int'($urandom_range(0, MAX_LEN)),
                     int'($urandom_range(0, 3)),
                     ($urandom % 64 == 0) ? 1 : 0,
                     ($urandom % 4 != 0) ? 1 : 0);
                n++;
            end
            chk("rand_ends", 32'(ph), 0);
            step(0, 0, 0, $urandom % 2, $urandom % 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proj_index_sequencer.md
# proj_index_sequencer

Parametrised index generator that walks the feature-map buffer for the MinHash projection stage. It supersedes the fixed-length free-running counter with the following additions:
- run-time programmable length and pass count
- a valid/ready handshake so downstream can stall
- abort, plus busy/done status

It sits between the projection controller and the FM buffer read port.

## Interface
Parameters:
- MAX_LEN, default proj_pkg::FM_BUFFER_SIZE: largest legal sweep length.
- IDX_W, default $clog2(MAX_LEN): index width.
- PASS_W, default 4: pass-count width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- cfg_len  in  IDX_W+1  sweep length, 1..MAX_LEN; latched on accepted start.
- cfg_passes  in  PASS_W  number of sweeps, 1..2^PASS_W-1; latched on accepted start.
- abort  in  1  terminate current run.
- index  out  IDX_W  current buffer index.
- index_valid  out  1  index is meaningful.
- index_ready  in  1  consumer accepts index this cycle.
- pass_idx  out  PASS_W  current sweep number, 0-based.
- last  out  1  high with index_valid on the final index of the final pass.
- busy  out  1  state is RUN.
- done  out  1  one-cycle pulse on normal completion.
- finished_count  out  1  sticky completion flag.
- cfg_err  out  1  one-cycle pulse when start is rejected for bad config.

## Operation
States: IDLE, RUN, DONE.

IDLE
- start=1 with cfg_len in 1..MAX_LEN and cfg_passes≠0:
  - latch len and passes;
  - index←0, pass_idx←0, finished_count←0;
  - go to RUN.
- start=1 with bad config: pulse cfg_err, stay IDLE, finished_count unchanged.

RUN
- index_valid=1, busy=1.
- A beat is accepted when index_valid && index_ready.
- On accept, non-final index (index<len-1): index+1.
- On accept at index=len-1, not final pass: index wraps to 0, pass_idx+1.
- On accept at index=len-1 of pass passes-1: go to DONE.
- No accept: index and pass_idx hold.
- start is ignored.

DONE
- Lasts one cycle.
- done=1, finished_count←1, index_valid=0.
- Then IDLE.

abort
- abort=1 in RUN takes priority over an accept in the same cycle.
- Next cycle: IDLE, index←0, pass_idx←0, index_valid=0.
- No done pulse; finished_count stays 0.
- abort in IDLE or DONE has no effect.

Rules
- Arithmetic is unsigned.
- len=MAX_LEN must reach index=MAX_LEN-1 without overflow of IDX_W.

## Timing
- Reset values:
  - index=0, pass_idx=0
  - index_valid=0, busy=0, done=0, last=0
  - finished_count=0, cfg_err=0
  - state IDLE
- Start latency: start high at edge T → index=0, index_valid=1 after T. The first beat can be accepted at T+1.
- Throughput: one index per cycle with index_ready held high. Total beats = len×passes.
- Completion: last accept at edge N → done=1 and finished_count=1 after N. IDLE follows after N+1. A new start is accepted at edge N+2 at earliest.
- Outputs are registered. index_ready is not combinationally tied to any output except through accept.
- Reset mid-run forces all reset values asynchronously. Release is synchronous to clk.

## Structure
- proj_pkg additions:
  - typedef enum seq_state_e {IDLE, RUN, DONE};
  - localparam SEQ_PASS_W=4.
  - Reuse FM_BUFFER_SIZE.
- Sub-module proj_wrap_counter:
  - enable, wrap-at-limit counter with a wrap output;
  - instantiated twice: index counter, and pass counter cascaded on wrap.
- FSM and status flags live in proj_index_sequencer.

## Test plan
- Reset then start, cfg_len=8, passes=1, ready=1 → index 0..7 on consecutive cycles; last with 7; done one cycle later; finished_count=1 and held.
- cfg_len=4, passes=3, ready toggled 1,0 → 12 accepted beats; pass_idx 0→1→2; index wraps 3→0; index holds during ready=0.
- cfg_len=MAX_LEN, passes=1 → reaches MAX_LEN-1, no overflow, done asserted.
- abort at index=5 of len=16 with ready=1 same cycle → next cycle IDLE, index=0, no done, finished_count=0; new start works.
- start with cfg_len=0, then cfg_passes=0 → cfg_err pulses, busy stays 0. start during RUN → ignored, sequence unchanged.
- rst asserted mid-run at index=3 → all outputs at reset values immediately; restart after release gives index 0.
